// File: rtl/rv32i_decode_execute.sv
// Single-cycle RV32I decode/execute slice: decoder, 32x32 register file, ALU and branch/jump unit.
// Zero-cycle combinational outputs; only register-file writes are clocked; no backpressure (new instruction every cycle).
module rv32i_decode_execute #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         inst_i,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic                wb_wen_i,
  input  logic [4:0]          wb_waddr_i,
  input  logic [DATA_LEN-1:0] wb_wdata_i,
  output logic [DATA_LEN-1:0] alu_result_o,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic                mem_wen_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic [1:0]          store_type_o,
  output logic [2:0]          load_type_o,
  output logic                branch_request_o,
  output logic [ADDR_LEN-1:0] branch_target_o,
  output logic                jmp_flag_o,
  output logic [ADDR_LEN-1:0] jmp_target_o,
  output logic                invalid_o,
  output logic                ebreak_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;

  assign opcode  = inst_i[6:0];
  assign funct3  = inst_i[14:12];
  assign funct7  = inst_i[31:25];
  assign rs1_idx = inst_i[19:15];
  assign rs2_idx = inst_i[24:20];

  logic [DATA_LEN-1:0] regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_wen_i && wb_waddr_i != 5'd0) begin
      regs[wb_waddr_i] <= wb_wdata_i;
    end
  end

  logic [DATA_LEN-1:0] rs1_val;
  logic [DATA_LEN-1:0] rs2_val;

  assign rs1_val = (rs1_idx == 5'd0) ? '0 : regs[rs1_idx];
  assign rs2_val = (rs2_idx == 5'd0) ? '0 : regs[rs2_idx];

  logic [DATA_LEN-1:0] imm_i;
  logic [DATA_LEN-1:0] imm_s;
  logic [DATA_LEN-1:0] imm_b;
  logic [DATA_LEN-1:0] imm_u;
  logic [DATA_LEN-1:0] imm_j;

  assign imm_i = DATA_LEN'($signed(inst_i[31:20]));
  assign imm_s = DATA_LEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_b = DATA_LEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign imm_u = DATA_LEN'($signed({inst_i[31:12], 12'b0}));
  assign imm_j = DATA_LEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));

  // Shared ALU for OP and OP-IMM; subtract only exists in the register form.
  logic [DATA_LEN-1:0] op_b;
  logic [DATA_LEN-1:0] alu_out;
  logic [4:0]          shamt;
  logic                sub_sel;

  assign op_b    = (opcode == OPC_OP) ? rs2_val : imm_i;
  assign shamt   = op_b[4:0];
  assign sub_sel = (opcode == OPC_OP) && inst_i[30];

  always_comb begin
    alu_out = '0;
    case (funct3)
      3'b000:  alu_out = sub_sel ? (rs1_val - op_b) : (rs1_val + op_b);
      3'b001:  alu_out = rs1_val << shamt;
      3'b010:  alu_out = {{(DATA_LEN-1){1'b0}}, ($signed(rs1_val) < $signed(op_b))};
      3'b011:  alu_out = {{(DATA_LEN-1){1'b0}}, (rs1_val < op_b)};
      3'b100:  alu_out = rs1_val ^ op_b;
      3'b101:  alu_out = inst_i[30] ? DATA_LEN'($signed(rs1_val) >>> shamt) : (rs1_val >> shamt);
      3'b110:  alu_out = rs1_val | op_b;
      default: alu_out = rs1_val & op_b;
    endcase
  end

  logic br_cond;

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'b000:  br_cond = (rs1_val == rs2_val);
      3'b001:  br_cond = (rs1_val != rs2_val);
      3'b100:  br_cond = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_cond = (rs1_val < rs2_val);
      3'b111:  br_cond = (rs1_val >= rs2_val);
      default: br_cond = 1'b0;
    endcase
  end

  assign wreg_o          = inst_i[11:7];
  assign mem_wdata_o     = rs2_val;
  assign branch_target_o = pc_i + ADDR_LEN'(imm_b);
  assign ebreak_o        = (inst_i == INST_EBREAK);
  assign mem_wen_o       = (store_type_o != 2'd0);

  always_comb begin
    alu_result_o     = '0;
    wd_o             = 1'b0;
    store_type_o     = 2'd0;
    load_type_o      = 3'd0;
    branch_request_o = 1'b0;
    jmp_flag_o       = 1'b0;
    jmp_target_o     = '0;
    invalid_o        = 1'b0;
    case (opcode)
      OPC_LUI: begin
        alu_result_o = imm_u;
        wd_o         = 1'b1;
      end
      OPC_AUIPC: begin
        alu_result_o = DATA_LEN'(pc_i + ADDR_LEN'(imm_u));
        wd_o         = 1'b1;
      end
      OPC_JAL: begin
        alu_result_o = DATA_LEN'(pc_i + ADDR_LEN'(4));
        wd_o         = 1'b1;
        jmp_flag_o   = 1'b1;
        jmp_target_o = pc_i + ADDR_LEN'(imm_j);
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          alu_result_o = DATA_LEN'(pc_i + ADDR_LEN'(4));
          wd_o         = 1'b1;
          jmp_flag_o   = 1'b1;
          jmp_target_o = ADDR_LEN'(rs1_val + imm_i) & ~ADDR_LEN'(1);
        end else begin
          invalid_o = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) invalid_o = 1'b1;
        else branch_request_o = br_cond;
      end
      OPC_LOAD: begin
        alu_result_o = rs1_val + imm_i;
        case (funct3)
          3'b000:  load_type_o = 3'd1;
          3'b001:  load_type_o = 3'd2;
          3'b010:  load_type_o = 3'd3;
          3'b100:  load_type_o = 3'd4;
          3'b101:  load_type_o = 3'd5;
          default: invalid_o   = 1'b1;
        endcase
        wd_o = !invalid_o;
        if (invalid_o) alu_result_o = '0;
      end
      OPC_STORE: begin
        if (funct3[2] || funct3 == 3'b011) begin
          invalid_o = 1'b1;
        end else begin
          alu_result_o = rs1_val + imm_s;
          store_type_o = funct3[1:0] + 2'd1;
        end
      end
      OPC_OPIMM: begin
        // Shift-immediates carry funct7 in the immediate field and must be well formed.
        if ((funct3 == 3'b001 && funct7 != 7'h00) ||
            (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)) begin
          invalid_o = 1'b1;
        end else begin
          alu_result_o = alu_out;
          wd_o         = 1'b1;
        end
      end
      OPC_OP: begin
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          alu_result_o = alu_out;
          wd_o         = 1'b1;
        end else begin
          invalid_o = 1'b1;
        end
      end
      default: invalid_o = (inst_i != INST_EBREAK);
    endcase
  end

endmodule

// File: tb/tb_rv32i_decode_execute.sv
// Directed plus randomized checks of the RV32I decode/execute slice against a mnemonic-level model.
module tb_rv32i_decode_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        wb_wen_i;
  logic [4:0]  wb_waddr_i;
  logic [31:0] wb_wdata_i;
  logic [31:0] alu_result_o;
  logic        wd_o;
  logic [4:0]  wreg_o;
  logic        mem_wen_o;
  logic [31:0] mem_wdata_o;
  logic [1:0]  store_type_o;
  logic [2:0]  load_type_o;
  logic        branch_request_o;
  logic [31:0] branch_target_o;
  logic        jmp_flag_o;
  logic [31:0] jmp_target_o;
  logic        invalid_o;
  logic        ebreak_o;

  rv32i_decode_execute #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .pc_i(pc_i),
    .wb_wen_i(wb_wen_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .alu_result_o(alu_result_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o),
    .store_type_o(store_type_o), .load_type_o(load_type_o),
    .branch_request_o(branch_request_o), .branch_target_o(branch_target_o),
    .jmp_flag_o(jmp_flag_o), .jmp_target_o(jmp_target_o),
    .invalid_o(invalid_o), .ebreak_o(ebreak_o)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [31:0] model_regs [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    wb_wen_i = 1'b1; wb_waddr_i = addr; wb_wdata_i = data;
    @(posedge clk);
    #1;
    wb_wen_i = 1'b0;
    if (addr != 5'd0) model_regs[addr] = data;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    @(negedge clk);
    inst_i = inst; pc_i = pc;
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] rand_data();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return {27'd0, r[4:0]};
      default: return r;
    endcase
  endfunction

  logic [31:0] bad_tab [9] = '{32'h0000_0000, 32'h0000_0073, 32'h0000_9067, 32'h0000_2063,
                               32'h0000_3003, 32'h0000_3023, 32'h0220_80b3, 32'h4000_9093,
                               32'h0000_000f};

  logic [31:0] a, b, si, ss, e_alu, e_jt, e_bt, tmp, pc;
  logic [4:0]  r1, r2, rd, sh;
  logic [11:0] imm12;
  logic [19:0] u20;
  logic [20:0] off21;
  logic [12:0] off13;
  logic        e_wd, e_br, e_jmp, e_inv, chk_alu, is_br, is_st;
  logic [1:0]  e_st;
  logic [2:0]  e_ld;
  logic [31:0] inst;
  int          kind;
  logic [2:0]  btab_f3 [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
  logic [2:0]  ltab_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0]  itab_f3 [6] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};

  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    rst = 1'b0; inst_i = '0; pc_i = '0;
    wb_wen_i = 1'b0; wb_waddr_i = '0; wb_wdata_i = '0;

    // Writes during reset must be blocked.
    @(negedge clk);
    wb_wen_i = 1'b1; wb_waddr_i = 5'd1; wb_wdata_i = 32'h1234_5678;
    inst_i = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd3);
    @(posedge clk); #1;
    wb_wen_i = 1'b0;
    check("reset_blocks_write", alu_result_o, 32'd0);
    rst = 1'b1;

    present(32'h0050_0093, 32'h8000_0000);
    check("addi_result", alu_result_o, 32'd5);
    check("addi_wd", {31'd0, wd_o}, 32'd1);
    check("addi_wreg", {27'd0, wreg_o}, 32'd1);
    check("addi_invalid", {31'd0, invalid_o}, 32'd0);

    wb_write(5'd1, 32'd5);
    present(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), 32'h8000_0004);
    check("add_x1_x1", alu_result_o, 32'd10);

    // Same-cycle write is not bypassed; visible only after the edge.
    @(negedge clk);
    inst_i = enc_r(7'h00, 5'd0, 5'd4, 3'b000, 5'd5);
    wb_wen_i = 1'b1; wb_waddr_i = 5'd4; wb_wdata_i = 32'd7;
    #1;
    check("no_bypass_old", alu_result_o, 32'd0);
    @(posedge clk); #1;
    wb_wen_i = 1'b0; model_regs[4] = 32'd7;
    check("no_bypass_new", alu_result_o, 32'd7);

    wb_write(5'd0, 32'hDEAD_BEEF);
    present(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd3), 32'h8000_0008);
    check("x0_protect", alu_result_o, 32'd0);

    wb_write(5'd2, 32'hFFFF_FFFF);
    present(enc_b(13'd8, 5'd1, 5'd2, 3'b100), 32'h8000_0000);
    check("blt_taken", {31'd0, branch_request_o}, 32'd1);
    check("blt_target", branch_target_o, 32'h8000_0008);
    check("blt_wd", {31'd0, wd_o}, 32'd0);
    present(enc_b(13'd8, 5'd1, 5'd2, 3'b110), 32'h8000_0000);
    check("bltu_not_taken", {31'd0, branch_request_o}, 32'd0);

    present(enc_j(21'd16, 5'd1), 32'h8000_0010);
    check("jal_flag", {31'd0, jmp_flag_o}, 32'd1);
    check("jal_target", jmp_target_o, 32'h8000_0020);
    check("jal_link", alu_result_o, 32'h8000_0014);

    wb_write(5'd6, 32'h8000_0101);
    present(enc_i(12'd0, 5'd6, 3'b000, 5'd0, 7'h67), 32'h8000_0000);
    check("jalr_target", jmp_target_o, 32'h8000_0100);

    wb_write(5'd1, 32'h0000_0100);
    present(enc_s(12'd4, 5'd2, 5'd1, 3'b010), 32'h8000_0000);
    check("sw_wen", {31'd0, mem_wen_o}, 32'd1);
    check("sw_type", {30'd0, store_type_o}, 32'd3);
    check("sw_addr", alu_result_o, 32'h0000_0104);
    check("sw_wdata", mem_wdata_o, 32'hFFFF_FFFF);
    present(enc_i(12'hFFF, 5'd1, 3'b100, 5'd5, 7'h03), 32'h8000_0000);
    check("lbu_type", {29'd0, load_type_o}, 32'd4);
    check("lbu_addr", alu_result_o, 32'h0000_00FF);
    check("lbu_wd", {31'd0, wd_o}, 32'd1);

    present(32'h0000_0000, 32'h8000_0000);
    check("zero_invalid", {31'd0, invalid_o}, 32'd1);
    check("zero_enables", {27'd0, wd_o, mem_wen_o, jmp_flag_o, branch_request_o, ebreak_o}, 32'd0);
    check("zero_types", {27'd0, store_type_o, load_type_o}, 32'd0);
    present(32'h0010_0073, 32'h8000_0000);
    check("ebreak_flag", {31'd0, ebreak_o}, 32'd1);
    check("ebreak_valid", {31'd0, invalid_o}, 32'd0);
    check("ebreak_wd", {31'd0, wd_o}, 32'd0);

    // Asynchronous reset mid-cycle, with a write attempted while held.
    present(enc_r(7'h00, 5'd0, 5'd1, 3'b000, 5'd7), 32'h8000_0000);
    check("pre_async_reset", alu_result_o, 32'h0000_0100);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_immediate", alu_result_o, 32'd0);
    wb_wen_i = 1'b1; wb_waddr_i = 5'd1; wb_wdata_i = 32'h5555_5555;
    @(posedge clk); #1;
    wb_wen_i = 1'b0;
    check("async_reset_holds", alu_result_o, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model_regs[i] = '0;

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) wb_write(5'($urandom_range(0, 31)), rand_data());
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      tmp = $urandom; imm12 = tmp[11:0]; u20 = tmp[31:12];
      tmp = $urandom; pc = tmp & 32'hFFFF_FFFC;
      tmp = $urandom; off21 = {tmp[19:0], 1'b0}; off13 = {tmp[31:20], 1'b0};
      sh = imm12[4:0];
      a = model_regs[r1]; b = model_regs[r2];
      si = {{20{imm12[11]}}, imm12};
      ss = si;
      e_alu = '0; e_wd = 1'b0; e_br = 1'b0; e_jmp = 1'b0; e_jt = '0; e_inv = 1'b0;
      e_st = '0; e_ld = '0; chk_alu = 1'b1; is_br = 1'b0; is_st = 1'b0; e_bt = '0;
      kind = $urandom_range(0, 37);
      if (kind == 0) begin
        inst = {u20, rd, 7'h37}; e_alu = {u20, 12'd0}; e_wd = 1'b1;
      end else if (kind == 1) begin
        inst = {u20, rd, 7'h17}; e_alu = pc + {u20, 12'd0}; e_wd = 1'b1;
      end else if (kind == 2) begin
        inst = enc_j(off21, rd); e_alu = pc + 32'd4; e_wd = 1'b1; e_jmp = 1'b1;
        e_jt = pc + {{11{off21[20]}}, off21};
      end else if (kind == 3) begin
        inst = enc_i(imm12, r1, 3'b000, rd, 7'h67); e_alu = pc + 32'd4; e_wd = 1'b1; e_jmp = 1'b1;
        e_jt = (a + si) & 32'hFFFF_FFFE;
      end else if (kind <= 9) begin
        inst = enc_b(off13, r2, r1, btab_f3[kind-4]); chk_alu = 1'b0; is_br = 1'b1;
        e_bt = pc + {{19{off13[12]}}, off13};
        case (kind)
          4: e_br = (a == b);
          5: e_br = (a != b);
          6: e_br = ($signed(a) < $signed(b));
          7: e_br = ($signed(a) >= $signed(b));
          8: e_br = (a < b);
          default: e_br = (a >= b);
        endcase
      end else if (kind <= 14) begin
        inst = enc_i(imm12, r1, ltab_f3[kind-10], rd, 7'h03);
        e_alu = a + si; e_wd = 1'b1; e_ld = 3'(kind - 9);
      end else if (kind <= 17) begin
        inst = enc_s(imm12, r2, r1, 3'(kind - 15)); e_alu = a + ss; e_st = 2'(kind - 14); is_st = 1'b1;
      end else if (kind <= 23) begin
        inst = enc_i(imm12, r1, itab_f3[kind-18], rd, 7'h13); e_wd = 1'b1;
        case (kind)
          18: e_alu = a + si;
          19: e_alu = ($signed(a) < $signed(si)) ? 32'd1 : 32'd0;
          20: e_alu = (a < si) ? 32'd1 : 32'd0;
          21: e_alu = a ^ si;
          22: e_alu = a | si;
          default: e_alu = a & si;
        endcase
      end else if (kind <= 26) begin
        e_wd = 1'b1;
        case (kind)
          24: begin inst = enc_i({7'h00, sh}, r1, 3'b001, rd, 7'h13); e_alu = a << sh; end
          25: begin inst = enc_i({7'h00, sh}, r1, 3'b101, rd, 7'h13); e_alu = a >> sh; end
          default: begin
            inst = enc_i({7'h20, sh}, r1, 3'b101, rd, 7'h13); e_alu = $unsigned($signed(a) >>> sh);
          end
        endcase
      end else if (kind <= 36) begin
        e_wd = 1'b1;
        case (kind)
          27: begin inst = enc_r(7'h00, r2, r1, 3'b000, rd); e_alu = a + b; end
          28: begin inst = enc_r(7'h20, r2, r1, 3'b000, rd); e_alu = a - b; end
          29: begin inst = enc_r(7'h00, r2, r1, 3'b001, rd); e_alu = a << b[4:0]; end
          30: begin inst = enc_r(7'h00, r2, r1, 3'b010, rd); e_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
          31: begin inst = enc_r(7'h00, r2, r1, 3'b011, rd); e_alu = (a < b) ? 32'd1 : 32'd0; end
          32: begin inst = enc_r(7'h00, r2, r1, 3'b100, rd); e_alu = a ^ b; end
          33: begin inst = enc_r(7'h00, r2, r1, 3'b101, rd); e_alu = a >> b[4:0]; end
          34: begin inst = enc_r(7'h20, r2, r1, 3'b101, rd); e_alu = $unsigned($signed(a) >>> b[4:0]); end
          35: begin inst = enc_r(7'h00, r2, r1, 3'b110, rd); e_alu = a | b; end
          default: begin inst = enc_r(7'h00, r2, r1, 3'b111, rd); e_alu = a & b; end
        endcase
      end else begin
        inst = bad_tab[$urandom_range(0, 8)]; e_inv = 1'b1; chk_alu = 1'b0;
      end

      present(inst, pc);
      check($sformatf("rnd%0d_k%0d_invalid", n, kind), {31'd0, invalid_o}, {31'd0, e_inv});
      check($sformatf("rnd%0d_k%0d_wd", n, kind), {31'd0, wd_o}, {31'd0, e_wd});
      if (e_wd) check($sformatf("rnd%0d_k%0d_wreg", n, kind), {27'd0, wreg_o}, {27'd0, rd});
      if (chk_alu) check($sformatf("rnd%0d_k%0d_alu", n, kind), alu_result_o, e_alu);
      check($sformatf("rnd%0d_k%0d_branch", n, kind), {31'd0, branch_request_o}, {31'd0, e_br});
      if (is_br) check($sformatf("rnd%0d_k%0d_btarget", n, kind), branch_target_o, e_bt);
      check($sformatf("rnd%0d_k%0d_jmp", n, kind), {31'd0, jmp_flag_o}, {31'd0, e_jmp});
      check($sformatf("rnd%0d_k%0d_jtarget", n, kind), jmp_target_o, e_jt);
      check($sformatf("rnd%0d_k%0d_types", n, kind), {27'd0, store_type_o, load_type_o}, {27'd0, e_st, e_ld});
      check($sformatf("rnd%0d_k%0d_memwen", n, kind), {31'd0, mem_wen_o}, {31'd0, (e_st != 2'd0)});
      if (is_st) check($sformatf("rnd%0d_k%0d_wdata", n, kind), mem_wdata_o, b);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
